// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit path: FSM states and the
// line-source select codes consumed by the downstream TX output mux.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_e;

   localparam logic [1:0] MUX_START = 2'b00;  // line driven low
   localparam logic [1:0] MUX_STOP  = 2'b01;  // line driven high (also idle)
   localparam logic [1:0] MUX_DATA  = 2'b10;
   localparam logic [1:0] MUX_PAR   = 2'b11;

endpackage

// File: rtl/uart_tx_parity.sv
// Combinational parity of the payload: XOR for even, XNOR for odd.
module uart_tx_parity #(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  odd,
   output logic                  par
);

   assign par = (^data) ^ odd;

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a captured payload as start, data (LSB
// first), optional parity and stop bits, steering the external line mux.
module uart_tx_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic [1:0]            mux_sel,
   output logic                  ser_data,
   output logic                  par_bit,
   output logic                  busy
);

   localparam int CNT_W = $clog2(DATA_WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

   tx_state_e             state, state_nxt;
   logic [DATA_WIDTH-1:0] shreg;
   logic [CNT_W-1:0]      cnt;
   logic                  par_q;
   logic                  par_en_q;
   logic                  par_calc;
   logic                  capture;

   uart_tx_parity #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data (p_data),
      .odd  (par_typ),
      .par  (par_calc)
   );

   assign capture = (state == IDLE) && data_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      mux_sel   = MUX_STOP;
      busy      = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (data_valid) state_nxt = START;
         end
         START: begin
            mux_sel   = MUX_START;
            state_nxt = DATA;
         end
         DATA: begin
            mux_sel = MUX_DATA;
            if (cnt == LAST_BIT) state_nxt = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            mux_sel   = MUX_PAR;
            state_nxt = STOP;
         end
         STOP:    state_nxt = IDLE;
         default: begin
            busy      = 1'b0;
            state_nxt = IDLE;
         end
      endcase
   end

   // Payload, parity and par_en are frozen at capture; inputs are ignored mid-frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg    <= '0;
         cnt      <= '0;
         par_q    <= 1'b0;
         par_en_q <= 1'b0;
      end else begin
         if (capture) begin
            shreg    <= p_data;
            par_q    <= par_calc;
            par_en_q <= par_en;
         end else if (state == DATA) begin
            shreg <= shreg >> 1;
         end
         if (state != DATA)       cnt <= '0;
         else if (cnt != LAST_BIT) cnt <= cnt + CNT_W'(1);
      end
   end

   assign ser_data = shreg[0];
   assign par_bit  = par_q;

endmodule
